// File: rtl/door_access_ctrl.sv
// Two-panel door access controller: round-robin sharing of one serial code
// checker, timed unlock pulse, and alarm lockout after repeated failures.
module door_access_ctrl #(
   parameter int                  CODE_LEN   = 7,
   parameter logic [CODE_LEN-1:0] CODE       = 7'b1101011,
   parameter int                  TIMEOUT    = 255,
   parameter int                  UNLOCK_CYC = 1000,
   parameter int                  MAX_FAIL   = 3,
   parameter int                  LOCK_CYC   = 5000
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           req_a,
   input  logic                           bit_valid_a,
   input  logic                           bit_a,
   input  logic                           req_b,
   input  logic                           bit_valid_b,
   input  logic                           bit_b,
   output logic                           gnt_a,
   output logic                           gnt_b,
   output logic                           unlock,
   output logic                           alarm,
   output logic [$clog2(MAX_FAIL+1)-1:0]  fail_cnt
);
   localparam int T_MAX0 = (TIMEOUT > UNLOCK_CYC) ? TIMEOUT : UNLOCK_CYC;
   localparam int T_MAX  = (T_MAX0 > LOCK_CYC) ? T_MAX0 : LOCK_CYC;
   localparam int TW     = $clog2(T_MAX + 1);
   localparam int FW     = $clog2(MAX_FAIL + 1);
   localparam int CW     = $clog2(CODE_LEN + 1);

   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] UNL_END  = TW'(UNLOCK_CYC);
   localparam logic [TW-1:0] LCK_END  = TW'(LOCK_CYC);
   localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);
   localparam logic [CW-1:0] CNT_LAST = CW'(CODE_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_CHECK,
      S_UNLOCK,
      S_LOCKOUT
   } state_t;

   state_t                state_q, state_d;
   logic                  gnt_a_q, gnt_a_d;
   logic                  gnt_b_q, gnt_b_d;
   logic                  unlock_q, unlock_d;
   logic                  alarm_q, alarm_d;
   logic                  rr_q, rr_d;          // 0: panel A wins a tie, 1: panel B
   logic [FW-1:0]         fail_cnt_q, fail_cnt_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [CODE_LEN-1:0]   shreg_q, shreg_d;

   logic                  accept;
   logic                  bit_in;
   logic                  req_own;
   logic                  grant_b;
   logic                  fail_now;
   logic [FW-1:0]         fail_inc;
   logic [TW-1:0]         timer_inc;

   assign accept    = (gnt_a_q & bit_valid_a) | (gnt_b_q & bit_valid_b);
   assign bit_in    = gnt_a_q ? bit_a : bit_b;
   assign req_own   = gnt_a_q ? req_a : req_b;
   assign fail_inc  = fail_cnt_q + FW'(1);
   assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TW'(1);

   always_comb begin
      state_d    = state_q;
      gnt_a_d    = gnt_a_q;
      gnt_b_d    = gnt_b_q;
      unlock_d   = 1'b0;
      alarm_d    = 1'b0;
      rr_d       = rr_q;
      fail_cnt_d = fail_cnt_q;
      cnt_d      = cnt_q;
      timer_d    = timer_q;
      shreg_d    = shreg_q;
      grant_b    = 1'b0;
      fail_now   = 1'b0;

      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            cnt_d   = '0;
            shreg_d = '0;
            if (req_a | req_b) begin
               if (req_a & req_b) begin
                  grant_b = rr_q;
                  rr_d    = ~rr_q;
               end else begin
                  grant_b = req_b;
               end
               gnt_a_d = ~grant_b;
               gnt_b_d = grant_b;
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            // Final bit beats a simultaneous req drop; any bit beats the timeout.
            if (accept && cnt_q == CNT_LAST) begin
               shreg_d = {shreg_q[CODE_LEN-2:0], bit_in};
               timer_d = '0;
               gnt_a_d = 1'b0;
               gnt_b_d = 1'b0;
               state_d = S_CHECK;
            end else if (!req_own) begin
               gnt_a_d = 1'b0;
               gnt_b_d = 1'b0;
               state_d = S_IDLE;
            end else if (accept) begin
               shreg_d = {shreg_q[CODE_LEN-2:0], bit_in};
               cnt_d   = cnt_q + CW'(1);
               timer_d = '0;
            end else if (timer_q == TO_LAST) begin
               fail_now = 1'b1;
            end else begin
               timer_d = timer_inc;
            end
         end
         S_CHECK: begin
            timer_d = '0;
            if (shreg_q == CODE) begin
               fail_cnt_d = '0;
               state_d    = S_UNLOCK;
            end else begin
               fail_now = 1'b1;
            end
         end
         S_UNLOCK: begin
            if (timer_q == UNL_END) begin
               timer_d = '0;
               state_d = S_IDLE;
            end else begin
               unlock_d = 1'b1;
               timer_d  = timer_inc;
            end
         end
         S_LOCKOUT: begin
            if (timer_q == LCK_END) begin
               timer_d    = '0;
               fail_cnt_d = '0;
               state_d    = S_IDLE;
            end else begin
               alarm_d = 1'b1;
               timer_d = timer_inc;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Timeouts and mismatches share one failure path.
      if (fail_now) begin
         fail_cnt_d = fail_inc;
         timer_d    = '0;
         gnt_a_d    = 1'b0;
         gnt_b_d    = 1'b0;
         state_d    = (fail_inc == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         gnt_a_q    <= 1'b0;
         gnt_b_q    <= 1'b0;
         unlock_q   <= 1'b0;
         alarm_q    <= 1'b0;
         rr_q       <= 1'b0;
         fail_cnt_q <= '0;
         cnt_q      <= '0;
         timer_q    <= '0;
         shreg_q    <= '0;
      end else begin
         state_q    <= state_d;
         gnt_a_q    <= gnt_a_d;
         gnt_b_q    <= gnt_b_d;
         unlock_q   <= unlock_d;
         alarm_q    <= alarm_d;
         rr_q       <= rr_d;
         fail_cnt_q <= fail_cnt_d;
         cnt_q      <= cnt_d;
         timer_q    <= timer_d;
         shreg_q    <= shreg_d;
      end
   end

   assign gnt_a    = gnt_a_q;
   assign gnt_b    = gnt_b_q;
   assign unlock   = unlock_q;
   assign alarm    = alarm_q;
   assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_door_access_ctrl.sv
// Directed bench for door_access_ctrl with short timers; outputs are packed
// as {gnt_a, gnt_b, unlock, alarm, fail_cnt[1:0]} for compact comparisons.
module tb_door_access_ctrl;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req_a = 1'b0, bit_valid_a = 1'b0, bit_a = 1'b0;
   logic       req_b = 1'b0, bit_valid_b = 1'b0, bit_b = 1'b0;
   logic       gnt_a, gnt_b, unlock, alarm;
   logic [1:0] fail_cnt;
   logic [5:0] outs;
   logic [6:0] good = 7'b1101011;
   logic [6:0] zero = 7'b0000000;
   int         vectors = 0;
   int         miscompares = 0;

   assign outs = {gnt_a, gnt_b, unlock, alarm, fail_cnt};

   door_access_ctrl #(
      .CODE_LEN(7), .CODE(7'b1101011), .TIMEOUT(8),
      .UNLOCK_CYC(4), .MAX_FAIL(3), .LOCK_CYC(10)
   ) dut (
      .clock(clock), .reset(reset),
      .req_a(req_a), .bit_valid_a(bit_valid_a), .bit_a(bit_a),
      .req_b(req_b), .bit_valid_b(bit_valid_b), .bit_b(bit_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .unlock(unlock), .alarm(alarm),
      .fail_cnt(fail_cnt)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // One bit per cycle, MSB first; optionally drop req on the final bit's edge.
   task automatic send_a(input logic [6:0] c, input bit drop_last);
      for (int i = 6; i >= 0; i--) begin
         bit_valid_a = 1'b1;
         bit_a       = c[i];
         if (i == 0 && drop_last) req_a = 1'b0;
         tick;
      end
      bit_valid_a = 1'b0;
      bit_a       = 1'b0;
   endtask

   task automatic send_b(input logic [6:0] c, input bit drop_last);
      for (int i = 6; i >= 0; i--) begin
         bit_valid_b = 1'b1;
         bit_b       = c[i];
         if (i == 0 && drop_last) req_b = 1'b0;
         tick;
      end
      bit_valid_b = 1'b0;
      bit_b       = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick;
      tick;
      vectors++;
      if (outs !== 6'b000000) begin
         miscompares++;
         $display("FAIL reset_outs: got %b expected 000000", outs);
      end
      reset = 1'b0;
      tick;
      vectors++;
      if (outs !== 6'b000000) begin
         miscompares++;
         $display("FAIL reset_idle: got %b expected 000000", outs);
      end
      $display("test_reset done");
   endtask

   task automatic test_correct_code;
      int first = -1;
      int ones  = 0;
      bit lost  = 1'b0;
      req_a = 1'b1;
      tick;
      vectors++;
      if (outs !== 6'b100000) begin
         miscompares++;
         $display("FAIL t1_grant: got %b expected 100000", outs);
      end
      for (int i = 6; i >= 0; i--) begin
         if (gnt_a !== 1'b1) lost = 1'b1;
         bit_valid_a = 1'b1;
         bit_a       = good[i];
         tick;
      end
      bit_valid_a = 1'b0;
      req_a       = 1'b0;
      vectors++;
      if (lost !== 1'b0) begin
         miscompares++;
         $display("FAIL t1_gnt_held: got lost=%b expected 0", lost);
      end
      vectors++;
      if (outs !== 6'b000000) begin
         miscompares++;
         $display("FAIL t1_check_cycle: got %b expected 000000", outs);
      end
      for (int k = 1; k <= 7; k++) begin
         tick;
         if (unlock === 1'b1 && first < 0) first = k;
         if (unlock === 1'b1) ones++;
      end
      vectors++;
      if (first !== 2) begin
         miscompares++;
         $display("FAIL t1_unlock_latency: got %0d expected 2", first);
      end
      vectors++;
      if (ones !== 4) begin
         miscompares++;
         $display("FAIL t1_unlock_width: got %0d expected 4", ones);
      end
      vectors++;
      if (outs !== 6'b000000) begin
         miscompares++;
         $display("FAIL t1_after: got %b expected 000000", outs);
      end
      $display("test_correct_code done");
   endtask

   task automatic test_round_robin;
      bit bad_b = 1'b0;
      req_a = 1'b1;
      req_b = 1'b1;
      tick;
      vectors++;
      if (outs !== 6'b100000) begin
         miscompares++;
         $display("FAIL t2_first_grant: got %b expected 100000", outs);
      end
      for (int i = 6; i >= 0; i--) begin
         bit_valid_a = 1'b1;
         bit_a       = good[i];
         bit_valid_b = 1'b1;
         bit_b       = ~good[i];
         if (i == 0) begin
            req_a = 1'b0;
            req_b = 1'b0;
         end
         tick;
         if (gnt_b !== 1'b0) bad_b = 1'b1;
      end
      bit_valid_a = 1'b0;
      bit_valid_b = 1'b0;
      vectors++;
      if (bad_b !== 1'b0) begin
         miscompares++;
         $display("FAIL t2_gnt_b_during_a: got %b expected 0", bad_b);
      end
      tick;
      tick;
      vectors++;
      if (outs !== 6'b001000) begin
         miscompares++;
         $display("FAIL t2_a_unlock: got %b expected 001000", outs);
      end
      for (int k = 0; k < 5; k++) tick;
      req_a = 1'b1;
      req_b = 1'b1;
      tick;
      vectors++;
      if (outs !== 6'b010000) begin
         miscompares++;
         $display("FAIL t2_second_grant: got %b expected 010000", outs);
      end
      req_a = 1'b0;
      send_b(good, 1'b1);
      tick;
      tick;
      vectors++;
      if (outs !== 6'b001000) begin
         miscompares++;
         $display("FAIL t2_b_unlock: got %b expected 001000", outs);
      end
      for (int k = 0; k < 5; k++) tick;
      $display("test_round_robin done");
   endtask

   task automatic test_lockout;
      int first = -1;
      int ones  = 0;
      bit granted = 1'b0;
      for (int r = 1; r <= 3; r++) begin
         req_a = 1'b1;
         tick;
         send_a(zero, r < 3);
         tick;
         vectors++;
         if (outs !== {4'b0000, 2'(r)}) begin
            miscompares++;
            $display("FAIL t3_fail_round%0d: got %b expected %b", r, outs, {4'b0000, 2'(r)});
         end
      end
      for (int k = 1; k <= 11; k++) begin
         tick;
         if (alarm === 1'b1 && first < 0) first = k;
         if (alarm === 1'b1) ones++;
         if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || unlock !== 1'b0) granted = 1'b1;
         if (k == 10) req_a = 1'b0;
      end
      vectors++;
      if (first !== 1) begin
         miscompares++;
         $display("FAIL t3_alarm_start: got %0d expected 1", first);
      end
      vectors++;
      if (ones !== 10) begin
         miscompares++;
         $display("FAIL t3_alarm_width: got %0d expected 10", ones);
      end
      vectors++;
      if (granted !== 1'b0) begin
         miscompares++;
         $display("FAIL t3_grant_in_lockout: got %b expected 0", granted);
      end
      tick;
      vectors++;
      if (outs !== 6'b000000) begin
         miscompares++;
         $display("FAIL t3_after_lockout: got %b expected 000000", outs);
      end
      $display("test_lockout done");
   endtask

   task automatic test_timeout;
      req_a = 1'b1;
      tick;
      for (int i = 6; i >= 4; i--) begin
         bit_valid_a = 1'b1;
         bit_a       = good[i];
         tick;
      end
      bit_valid_a = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick;
         if (k == 7) begin
            vectors++;
            if (outs !== 6'b100000) begin
               miscompares++;
               $display("FAIL t4_before_timeout: got %b expected 100000", outs);
            end
         end
      end
      vectors++;
      if (outs !== 6'b000001) begin
         miscompares++;
         $display("FAIL t4_timeout: got %b expected 000001", outs);
      end
      req_a = 1'b0;
      tick;
      vectors++;
      if (outs !== 6'b000001) begin
         miscompares++;
         $display("FAIL t4_idle_after: got %b expected 000001", outs);
      end
      // A bit arriving on the expiry edge keeps the attempt alive.
      req_a = 1'b1;
      tick;
      for (int i = 6; i >= 4; i--) begin
         bit_valid_a = 1'b1;
         bit_a       = good[i];
         tick;
      end
      bit_valid_a = 1'b0;
      for (int k = 1; k <= 7; k++) tick;
      bit_valid_a = 1'b1;
      bit_a       = good[3];
      tick;
      vectors++;
      if (outs !== 6'b100001) begin
         miscompares++;
         $display("FAIL t4_bit_beats_timeout: got %b expected 100001", outs);
      end
      for (int i = 2; i >= 0; i--) begin
         bit_valid_a = 1'b1;
         bit_a       = good[i];
         if (i == 0) req_a = 1'b0;
         tick;
      end
      bit_valid_a = 1'b0;
      tick;
      tick;
      vectors++;
      if (outs !== 6'b001000) begin
         miscompares++;
         $display("FAIL t4_late_unlock: got %b expected 001000", outs);
      end
      for (int k = 0; k < 5; k++) tick;
      $display("test_timeout done");
   endtask

   task automatic test_abort;
      req_a = 1'b1;
      tick;
      send_a(zero, 1'b1);
      tick;
      vectors++;
      if (outs !== 6'b000001) begin
         miscompares++;
         $display("FAIL t5_setup_fail: got %b expected 000001", outs);
      end
      req_a = 1'b1;
      tick;
      for (int i = 6; i >= 3; i--) begin
         bit_valid_a = 1'b1;
         bit_a       = good[i];
         tick;
      end
      bit_valid_a = 1'b0;
      req_a       = 1'b0;
      tick;
      vectors++;
      if (outs !== 6'b000001) begin
         miscompares++;
         $display("FAIL t5_abort: got %b expected 000001", outs);
      end
      req_a = 1'b1;
      tick;
      vectors++;
      if (outs !== 6'b100001) begin
         miscompares++;
         $display("FAIL t5_regrant: got %b expected 100001", outs);
      end
      send_a(good, 1'b1);
      vectors++;
      if (outs !== 6'b000001) begin
         miscompares++;
         $display("FAIL t5_drop_on_last: got %b expected 000001", outs);
      end
      tick;
      tick;
      vectors++;
      if (outs !== 6'b001000) begin
         miscompares++;
         $display("FAIL t5_unlock: got %b expected 001000", outs);
      end
      for (int k = 0; k < 5; k++) tick;
      $display("test_abort done");
   endtask

   task automatic test_reset_mid;
      req_a = 1'b1;
      tick;
      send_a(zero, 1'b1);
      tick;
      req_a = 1'b1;
      req_b = 1'b1;
      tick;
      vectors++;
      if (outs !== 6'b100001) begin
         miscompares++;
         $display("FAIL t6_collect_grant: got %b expected 100001", outs);
      end
      for (int i = 6; i >= 5; i--) begin
         bit_valid_a = 1'b1;
         bit_a       = good[i];
         tick;
      end
      bit_valid_a = 1'b0;
      reset = 1'b1;
      tick;
      vectors++;
      if (outs !== 6'b000000) begin
         miscompares++;
         $display("FAIL t6_reset_collect: got %b expected 000000", outs);
      end
      reset = 1'b0;
      tick;
      vectors++;
      if (outs !== 6'b100000) begin
         miscompares++;
         $display("FAIL t6_rr_after_reset: got %b expected 100000", outs);
      end
      req_b = 1'b0;
      send_a(good, 1'b1);
      tick;
      tick;
      tick;
      vectors++;
      if (outs !== 6'b001000) begin
         miscompares++;
         $display("FAIL t6_unlock_before_reset: got %b expected 001000", outs);
      end
      reset = 1'b1;
      tick;
      vectors++;
      if (outs !== 6'b000000) begin
         miscompares++;
         $display("FAIL t6_reset_unlock: got %b expected 000000", outs);
      end
      reset = 1'b0;
      req_a = 1'b1;
      tick;
      vectors++;
      if (outs !== 6'b100000) begin
         miscompares++;
         $display("FAIL t6_idle_after_reset: got %b expected 100000", outs);
      end
      req_a = 1'b0;
      tick;
      vectors++;
      if (outs !== 6'b000000) begin
         miscompares++;
         $display("FAIL t6_release: got %b expected 000000", outs);
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset;
      test_correct_code;
      test_round_robin;
      test_lockout;
      test_timeout;
      test_abort;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
